// File: rtl/irq_pending_controller.sv
// Rising-edge request capture with per-source masking, highest-index selection
// and a valid/ready presentation handshake that retires the accepted source.
module irq_pending_controller #(
   parameter  int N    = 4,
   localparam int ID_W = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    irq_in,
   input  logic [N-1:0]    mask,
   input  logic            irq_ready,
   input  logic            overrun_clr,
   output logic            irq_valid,
   output logic [ID_W-1:0] irq_id,
   output logic            any_pending,
   output logic [N-1:0]    pending,
   output logic [N-1:0]    overrun
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESENT,
      ST_GAP
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_irq_q;
   logic [N-1:0]    r_pending;
   logic [N-1:0]    r_overrun;
   logic            r_valid;
   logic [ID_W-1:0] r_id;
   logic            r_any;

   logic [N-1:0]    w_rise;
   logic [N-1:0]    w_active;
   logic            w_accept;
   logic [ID_W-1:0] w_sel;
   logic [N-1:0]    w_pend_nxt;
   logic [N-1:0]    w_ovr_nxt;

   assign w_rise   = irq_in & ~r_irq_q;
   assign w_active = r_pending & mask;
   assign w_accept = r_valid & irq_ready;

   // Ascending scan so the highest active index is the last one written.
   always_comb begin
      w_sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_active[i]) w_sel = ID_W'(i);
      end
   end

   always_comb begin
      w_pend_nxt = r_pending;
      w_ovr_nxt  = r_overrun;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_rise[i]) begin
            w_pend_nxt[i] = 1'b1;
         end else if (w_accept && (r_id == ID_W'(i))) begin
            w_pend_nxt[i] = 1'b0;
         end
         // A rise that lands on the accept cycle of its own source is a fresh event.
         if (w_rise[i] && r_pending[i] && !(w_accept && (r_id == ID_W'(i)))) begin
            w_ovr_nxt[i] = 1'b1;
         end else if (overrun_clr) begin
            w_ovr_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_irq_q   <= irq_in;
         r_pending <= '0;
         r_overrun <= '0;
         r_valid   <= 1'b0;
         r_id      <= '0;
         r_any     <= 1'b0;
      end else begin
         r_irq_q   <= irq_in;
         r_pending <= w_pend_nxt;
         r_overrun <= w_ovr_nxt;
         r_any     <= |w_active;
         case (r_state)
            ST_IDLE: begin
               if (|w_active) begin
                  r_id    <= w_sel;
                  r_valid <= 1'b1;
                  r_state <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (w_accept) begin
                  r_valid <= 1'b0;
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign irq_valid   = r_valid;
   assign irq_id      = r_id;
   assign any_pending = r_any;
   assign pending     = r_pending;
   assign overrun     = r_overrun;

endmodule
